pgm_wrr_sched: RTL and testbench

- Weighted round-robin packet scheduler for the 8-flow packet generation datapath.
- Receives per-flow eligibility from the gate-control stage. Each eligible bit means the gate is open and the token bucket has a request pending.
- Issues a single-cycle one-hot grant to the header-read and header-edit stages, then holds off further grants until the datapath reports end of packet.
- Grants are gated by output FIFO headroom and the test-start enable.
- Replaces the plain first-valid selection with per-flow weights and a watchdog.

---
 rtl/pgm_wrr_sched.sv | 149 ++++++++++++++
 tb/tb_pgm_wrr_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_wrr_sched.sv
// Weighted round-robin scheduler for the 8-flow packet generator.
// Grants one eligible flow at a time, lets each flow send up to its weight
// in consecutive packets, then waits for end of packet (or a watchdog
// expiry) before arbitrating again.
module pgm_wrr_sched #(
    parameter int N_FLOW      = 8,
    parameter int USEDW_W     = 7,
    parameter int FIFO_THRESH = 96,
    parameter int WEIGHT_W    = 4,
    parameter int TIMEOUT     = 2048
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_test_start,
    input  logic [N_FLOW-1:0]            iv_valid,
    input  logic [N_FLOW*WEIGHT_W-1:0]   iv_weight,
    input  logic [USEDW_W-1:0]           iv_fifo_usedw,
    input  logic                         i_pkt_done,
    input  logic                         i_cnt_rst,
    output logic [N_FLOW-1:0]            ov_selected,
    output logic                         o_busy,
    output logic                         o_timeout,
    output logic [31:0]                  ov_grant_cnt
);

    localparam int PTR_W = (N_FLOW > 1) ? $clog2(N_FLOW) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ARB, RELOAD, WAIT} state_t;

    state_t                              state, state_d;
    logic [PTR_W-1:0]                    ptr, ptr_d;
    logic [N_FLOW-1:0][WEIGHT_W-1:0]     credit, credit_d;
    logic [WD_W-1:0]                     wdog, wdog_d;
    logic [31:0]                         grant_cnt, grant_cnt_d;
    logic [N_FLOW-1:0]                   sel_d;
    logic                                busy_d;
    logic                                timeout_d;
    logic                                grant_inc;
    logic                                found;
    logic [PTR_W-1:0]                    cand;
    logic                                arb_en;

    assign arb_en       = i_test_start && (iv_fifo_usedw <= USEDW_W'(FIFO_THRESH));
    assign ov_grant_cnt = grant_cnt;

    // Circular search from the pointer for the first eligible flow with credit left.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_FLOW; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N_FLOW;
            if (!found && iv_valid[idx] && (credit[idx] != '0)) begin
                found = 1'b1;
                cand  = PTR_W'(idx);
            end
        end
    end

    // Next-state and next-output logic for ARB / RELOAD / WAIT.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        credit_d  = credit;
        wdog_d    = wdog;
        sel_d     = '0;
        busy_d    = o_busy;
        timeout_d = 1'b0;
        grant_inc = 1'b0;
        case (state)
            ARB: begin
                if (arb_en) begin
                    if (found) begin
                        sel_d          = N_FLOW'(1) << cand;
                        busy_d         = 1'b1;
                        grant_inc      = 1'b1;
                        credit_d[cand] = credit[cand] - WEIGHT_W'(1);
                        wdog_d         = WD_W'(1);
                        state_d        = WAIT;
                        // Stay on the flow until its last credit is spent.
                        if (credit[cand] == WEIGHT_W'(1))
                            ptr_d = (cand == PTR_W'(N_FLOW - 1)) ? '0 : cand + PTR_W'(1);
                    end else if (iv_valid != '0) begin
                        state_d = RELOAD;
                    end
                end
            end
            RELOAD: begin
                for (int k = 0; k < N_FLOW; k++) begin
                    credit_d[k] = (iv_weight[k*WEIGHT_W +: WEIGHT_W] == '0)
                                ? WEIGHT_W'(1) : iv_weight[k*WEIGHT_W +: WEIGHT_W];
                end
                state_d = ARB;
            end
            WAIT: begin
                // Done wins over a simultaneous watchdog expiry.
                if (i_pkt_done) begin
                    busy_d  = 1'b0;
                    wdog_d  = '0;
                    state_d = ARB;
                end else if (wdog == WD_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    wdog_d    = '0;
                    state_d   = ARB;
                end else begin
                    wdog_d = wdog + WD_W'(1);
                end
            end
            default: state_d = ARB;
        endcase

        // Clear has priority over an increment in the same cycle.
        if (i_cnt_rst)
            grant_cnt_d = '0;
        else if (grant_inc)
            grant_cnt_d = grant_cnt + 32'd1;
        else
            grant_cnt_d = grant_cnt;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state       <= ARB;
            ptr         <= '0;
            // NOTE: the credit array is reset because arbitration reads it on the first cycle.
            credit      <= '0;
            wdog        <= '0;
            grant_cnt   <= '0;
            ov_selected <= '0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            credit      <= credit_d;
            wdog        <= wdog_d;
            grant_cnt   <= grant_cnt_d;
            ov_selected <= sel_d;
            o_busy      <= busy_d;
            o_timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pgm_wrr_sched.sv
// Self-checking bench for pgm_wrr_sched: expected grants and inter-grant
// gaps are queued per scenario and compared as grants appear.
module tb_pgm_wrr_sched;

    localparam int N_FLOW      = 8;
    localparam int USEDW_W     = 7;
    localparam int FIFO_THRESH = 96;
    localparam int WEIGHT_W    = 4;
    localparam int TIMEOUT     = 2048;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        i_test_start;
    logic [N_FLOW-1:0]           iv_valid;
    logic [N_FLOW*WEIGHT_W-1:0]  iv_weight;
    logic [USEDW_W-1:0]          iv_fifo_usedw;
    logic                        i_pkt_done;
    logic                        i_cnt_rst;
    logic [N_FLOW-1:0]           ov_selected;
    logic                        o_busy;
    logic                        o_timeout;
    logic [31:0]                 ov_grant_cnt;

    typedef struct {
        logic [N_FLOW-1:0] sel;
        int                gap;   // cycles since previous grant, 0 = don't check
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc = 0;
    int   last_grant_cyc = 0;

    pgm_wrr_sched #(
        .N_FLOW(N_FLOW), .USEDW_W(USEDW_W), .FIFO_THRESH(FIFO_THRESH),
        .WEIGHT_W(WEIGHT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .i_test_start(i_test_start), .iv_valid(iv_valid),
        .iv_weight(iv_weight), .iv_fifo_usedw(iv_fifo_usedw), .i_pkt_done(i_pkt_done),
        .i_cnt_rst(i_cnt_rst), .ov_selected(ov_selected), .o_busy(o_busy),
        .o_timeout(o_timeout), .ov_grant_cnt(ov_grant_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, n_fails=%0d", n_fails);
        $fatal(1, "global timeout");
    end

    task automatic push(input logic [N_FLOW-1:0] s, input int g);
        exp_t e;
        e.sel = s;
        e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        i_test_start  = 1'b1;
        iv_valid      = '0;
        iv_weight     = {N_FLOW{4'd1}};
        iv_fifo_usedw = '0;
        i_pkt_done    = 1'b0;
        i_cnt_rst     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse done so the DUT samples it d cycles after the grant-visible cycle.
    task automatic serve(input int d);
        repeat (d) @(negedge clk);
        i_pkt_done = 1'b1;
        @(negedge clk);
        i_pkt_done = 1'b0;
    endtask

    // Wait (bounded) for the next grant and compare it against the queue head.
    task automatic observe_grant(input string name, output bit ok);
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov_selected != '0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s_wait: no grant within 40 cycles, expected one", name);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL %s_extra: got grant %h, expected none queued", name, ov_selected);
            return;
        end
        e = exp_q.pop_front();
        if (ov_selected !== e.sel) begin
            n_fails++;
            $display("FAIL %s_sel: got %h, expected %h", name, ov_selected, e.sel);
        end
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fails++;
            $display("FAIL %s_busy: got %b, expected 1", name, o_busy);
        end
        if (e.gap != 0) begin
            n_checks++;
            if (cyc - last_grant_cyc != e.gap) begin
                n_fails++;
                $display("FAIL %s_gap: got %0d cycles, expected %0d", name, cyc - last_grant_cyc, e.gap);
            end
        end
        last_grant_cyc = cyc;
    endtask

    task automatic consume(input string name, input int n, input int d);
        bit ok;
        for (int i = 0; i < n; i++) begin
            observe_grant(name, ok);
            if (ok) serve(d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        iv_valid = '1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ov_selected !== '0) begin n_fails++; $display("FAIL reset_sel: got %h, expected 00", ov_selected); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
        n_checks++;
        if (o_timeout !== 1'b0) begin n_fails++; $display("FAIL reset_timeout: got %b, expected 0", o_timeout); end
        n_checks++;
        if (ov_grant_cnt !== 32'd0) begin n_fails++; $display("FAIL reset_cnt: got %h, expected 0", ov_grant_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        iv_valid = 8'hFF;
        push(8'h01, 0);
        for (int k = 1; k < N_FLOW; k++) push(8'h01 << k, 4);
        push(8'h01, 6);   // one RELOAD cycle before wrapping to flow 0
        consume("rr", 9, 2);
        n_checks++;
        if (ov_grant_cnt !== 32'd9) begin n_fails++; $display("FAIL rr_cnt: got %0d, expected 9", ov_grant_cnt); end
    endtask

    task automatic test_weights();
        do_reset();
        iv_weight[3:0] = 4'd3;
        iv_weight[7:4] = 4'd0;   // zero weight behaves as one
        iv_valid = 8'h03;
        push(8'h01, 0); push(8'h01, 4); push(8'h01, 4); push(8'h02, 4);
        push(8'h01, 6); push(8'h01, 4); push(8'h01, 4); push(8'h02, 4);
        consume("wrr", 8, 2);
    endtask

    task automatic test_fifo_thresh();
        bit idle_ok;
        do_reset();
        iv_weight[3:0] = 4'd15;
        iv_valid = 8'h01;
        push(8'h01, 0);
        consume("fifo", 1, 2);
        iv_fifo_usedw = 7'd97;
        idle_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ov_selected != '0 || o_busy) idle_ok = 1'b0;
        end
        n_checks++;
        if (!idle_ok) begin n_fails++; $display("FAIL fifo_hold: got a grant at usedw=97, expected none"); end
        iv_fifo_usedw = 7'd96;
        @(negedge clk);
        n_checks++;
        if (ov_selected !== 8'h01) begin n_fails++; $display("FAIL fifo_release: got %h, expected 01", ov_selected); end
        n_checks++;
        if (ov_grant_cnt !== 32'd2) begin n_fails++; $display("FAIL fifo_cnt: got %0d, expected 2", ov_grant_cnt); end
        serve(0);
    endtask

    task automatic test_timeout();
        bit ok;
        int j;
        do_reset();
        iv_weight[3:0] = 4'd15;
        iv_valid = 8'h01;
        push(8'h01, 0);
        observe_grant("wd", ok);
        j = 0;
        for (int i = 1; i <= TIMEOUT + 50; i++) begin
            @(negedge clk);
            if (o_timeout) begin j = i; break; end
        end
        n_checks++;
        if (j != TIMEOUT) begin n_fails++; $display("FAIL wd_expiry: got pulse after %0d cycles, expected %0d", j, TIMEOUT); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fails++; $display("FAIL wd_busy: got %b, expected 0", o_busy); end
        @(negedge clk);
        n_checks++;
        if (o_timeout !== 1'b0) begin n_fails++; $display("FAIL wd_pulse_len: got %b, expected 0", o_timeout); end
        n_checks++;
        if (ov_selected !== 8'h01) begin n_fails++; $display("FAIL wd_regrant: got %h, expected 01", ov_selected); end
        // Done arrives in the very cycle the watchdog would expire.
        repeat (TIMEOUT - 1) @(negedge clk);
        i_pkt_done = 1'b1;
        @(negedge clk);
        i_pkt_done = 1'b0;
        n_checks++;
        if (o_timeout !== 1'b0) begin n_fails++; $display("FAIL wd_done_wins: got timeout %b, expected 0", o_timeout); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fails++; $display("FAIL wd_done_busy: got %b, expected 0", o_busy); end
        do_reset();
    endtask

    task automatic test_start_gate();
        bit ok;
        bit idle_ok;
        do_reset();
        iv_valid = 8'hFF;
        push(8'h01, 0);
        observe_grant("start", ok);
        i_test_start = 1'b0;
        serve(2);
        idle_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov_selected != '0 || o_busy) idle_ok = 1'b0;
        end
        n_checks++;
        if (!idle_ok) begin n_fails++; $display("FAIL start_hold: got activity while i_test_start low, expected none"); end
        i_test_start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ov_selected !== 8'h02) begin n_fails++; $display("FAIL start_resume: got %h, expected 02", ov_selected); end
        last_grant_cyc = cyc;
        serve(2);
        push(8'h04, 4);
        consume("start", 1, 2);
    endtask

    task automatic test_cnt_rst();
        bit ok;
        do_reset();
        iv_weight[3:0] = 4'd15;
        iv_valid = 8'h01;
        push(8'h01, 0);
        observe_grant("cnt", ok);
        i_test_start = 1'b0;
        serve(2);
        n_checks++;
        if (ov_grant_cnt !== 32'd1) begin n_fails++; $display("FAIL cnt_first: got %0d, expected 1", ov_grant_cnt); end
        repeat (3) @(negedge clk);
        i_test_start = 1'b1;
        i_cnt_rst    = 1'b1;
        @(negedge clk);
        i_cnt_rst    = 1'b0;
        i_test_start = 1'b0;
        n_checks++;
        if (ov_selected !== 8'h01) begin n_fails++; $display("FAIL cnt_rst_grant: got %h, expected 01", ov_selected); end
        n_checks++;
        if (ov_grant_cnt !== 32'd0) begin n_fails++; $display("FAIL cnt_rst_prio: got %0d, expected 0", ov_grant_cnt); end
        serve(2);
        force dut.grant_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.grant_cnt;
        i_test_start = 1'b1;
        @(negedge clk);
        i_test_start = 1'b0;
        n_checks++;
        if (ov_selected !== 8'h01) begin n_fails++; $display("FAIL cnt_wrap_grant: got %h, expected 01", ov_selected); end
        n_checks++;
        if (ov_grant_cnt !== 32'd0) begin n_fails++; $display("FAIL cnt_wrap: got %h, expected 00000000", ov_grant_cnt); end
        serve(0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_weights();
        test_fifo_thresh();
        test_timeout();
        test_start_gate();
        test_cnt_rst();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
